// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory pins around dmem_arbiter.
interface dmem_arbiter_if;
  logic        p0_req, p1_req;
  logic        p0_we, p1_we;
  logic [31:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt;
  logic        p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_err, p1_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, p0_err, p1_err,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, p0_err, p1_err,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 priority with an aging guard for port 1,
// alignment/range check, one-cycle memory strobes and a registered response.
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int MAX_WAIT  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  localparam int              WW       = $clog2(MAX_WAIT + 1);
  localparam logic [31:0]     ADDR_MAX = 32'(MEM_BYTES - 4);
  localparam logic [WW-1:0]   WAIT_SAT = WW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          cmd_port, cmd_rd, cmd_err;

  logic          any_req, pick1, win_we, win_err;
  logic [31:0]   win_addr, win_wdata;

  always_comb begin
    any_req   = bus.p0_req | bus.p1_req;
    pick1     = bus.p1_req & (~bus.p0_req | (wait_cnt == WAIT_SAT));
    win_we    = pick1 ? bus.p1_we    : bus.p0_we;
    win_addr  = pick1 ? bus.p1_addr  : bus.p0_addr;
    win_wdata = pick1 ? bus.p1_wdata : bus.p0_wdata;
    win_err   = (win_addr[1:0] != 2'b00) || (win_addr > ADDR_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      cmd_port      <= 1'b0;
      cmd_rd        <= 1'b0;
      cmd_err       <= 1'b0;
      bus.p0_gnt    <= 1'b0;
      bus.p1_gnt    <= 1'b0;
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
      bus.p0_err    <= 1'b0;
      bus.p1_err    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_write <= 1'b0;
      bus.mem_read  <= 1'b0;
    end else begin
      bus.p0_gnt    <= 1'b0;
      bus.p1_gnt    <= 1'b0;
      bus.p0_rvalid <= 1'b0;
      bus.p1_rvalid <= 1'b0;
      bus.p0_rdata  <= '0;
      bus.p1_rdata  <= '0;
      bus.p0_err    <= 1'b0;
      bus.p1_err    <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_read  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (any_req) begin
            state      <= ACCESS;
            cmd_port   <= pick1;
            cmd_rd     <= ~win_we & ~win_err;
            cmd_err    <= win_err;
            bus.p0_gnt <= ~pick1;
            bus.p1_gnt <= pick1;
            // Faulting accesses never reach the memory pins; address/data hold.
            if (!win_err) begin
              bus.mem_addr  <= win_addr;
              bus.mem_wdata <= win_wdata;
              bus.mem_write <= win_we;
              bus.mem_read  <= ~win_we;
            end
            if (pick1)
              wait_cnt <= '0;
            else if (bus.p1_req && wait_cnt != WAIT_SAT)
              wait_cnt <= wait_cnt + WW'(1);
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (cmd_port) begin
            bus.p1_rvalid <= 1'b1;
            bus.p1_err    <= cmd_err;
            bus.p1_rdata  <= cmd_rd ? bus.mem_rdata : '0;
          end else begin
            bus.p0_rvalid <= 1'b1;
            bus.p0_err    <= cmd_err;
            bus.p0_rdata  <= cmd_rd ? bus.mem_rdata : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a negedge-sampling word memory model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_BYTES(1024), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256] = '{0: 32'hA5A5_0000, 255: 32'h0C0F_FEE0, default: 32'h0};

  always @(negedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
    if (bus.mem_read)  bus.mem_rdata = mem[bus.mem_addr[9:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_flags"}, {24'h0, bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid,
                          bus.p0_err, bus.p1_err, bus.mem_write, bus.mem_read}, 32'h0);
    chk({tag, "_rdata"}, bus.p0_rdata | bus.p1_rdata, 32'h0);
  endtask

  task automatic req0(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
  endtask

  task automatic req1(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
  endtask

  // Single uncontended p0 access from IDLE; returns to IDLE afterwards.
  task automatic p0_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err,
                           input logic [31:0] exp_rdata);
    req0(we, addr, wdata);
    step();
    chk({tag, "_gnt"}, bus.p0_gnt, 1'b1);
    chk({tag, "_strobe"}, {bus.mem_write, bus.mem_read},
        exp_err ? 2'b00 : (we ? 2'b10 : 2'b01));
    bus.p0_req = 1'b0;
    step();
    chk({tag, "_rvalid"}, {bus.p0_rvalid, bus.p1_rvalid}, 2'b10);
    chk({tag, "_err"}, bus.p0_err, exp_err);
    chk({tag, "_rdata"}, bus.p0_rdata, exp_rdata);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    bus.mem_rdata = '0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk_quiet("reset_idle");
    chk("reset_maddr", bus.mem_addr, 32'h0);
    chk("reset_mwdata", bus.mem_wdata, 32'h0);

    // Write then read back through p0.
    p0_access("wr8", 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, 32'h0);
    chk("wr8_mem", mem[2], 32'hDEAD_BEEF);
    p0_access("rd8", 1'b0, 32'h8, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // Simultaneous: p0 read 0x0 first, p1 write 0x10 granted at the RESP edge.
    req0(1'b0, 32'h0, 32'h0);
    req1(1'b1, 32'h10, 32'h1234_5678);
    step();
    chk("both_gnt_e0", {bus.p0_gnt, bus.p1_gnt}, 2'b10);
    bus.p0_req = 1'b0;
    step();
    chk("both_rv0", {bus.p0_rvalid, bus.p1_rvalid}, 2'b10);
    chk("both_rdata0", bus.p0_rdata, 32'hA5A5_0000);
    step();
    chk("both_gnt_e2", {bus.p0_gnt, bus.p1_gnt}, 2'b01);
    chk("both_maddr", bus.mem_addr, 32'h10);
    chk("both_mwrite", bus.mem_write, 1'b1);
    bus.p1_req = 1'b0;
    step();
    chk("both_rv1", {bus.p0_rvalid, bus.p1_rvalid, bus.p1_err}, 3'b010);
    chk("both_rdata1", bus.p1_rdata, 32'h0);
    chk("both_p0_quiet", bus.p0_rdata, 32'h0);
    step();
    p0_access("rd10", 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_5678);

    // Starvation guard: four p0 wins, then p1, repeating.
    req0(1'b0, 32'h0, 32'h0);
    req1(1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("starve_gnt", {bus.p0_gnt, bus.p1_gnt}, (i % 5 == 4) ? 2'b01 : 2'b10);
      step();
    end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    step();

    // Misaligned p1 read.
    req1(1'b0, 32'h6, 32'h0);
    step();
    chk("bad6_gnt", bus.p1_gnt, 1'b1);
    chk("bad6_strobe", {bus.mem_write, bus.mem_read}, 2'b00);
    bus.p1_req = 1'b0;
    step();
    chk("bad6_resp", {bus.p1_rvalid, bus.p1_err, bus.p0_rvalid}, 3'b110);
    chk("bad6_rdata", bus.p1_rdata, 32'h0);
    step();

    // Out-of-range and misaligned writes leave the top word intact.
    p0_access("bad3fe", 1'b1, 32'h3FE, 32'h0BAD_0BAD, 1'b1, 32'h0);
    p0_access("bad400", 1'b1, 32'h400, 32'h0BAD_0BAD, 1'b1, 32'h0);
    p0_access("rd3fc", 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0C0F_FEE0);

    // Reset during ACCESS of a p1 write: response dropped, write already done.
    req1(1'b1, 32'h20, 32'h0000_0055);
    step();
    chk("rst_acc_gnt", bus.p1_gnt, 1'b1);
    bus.p1_req = 1'b0;
    rst_n = 1'b0;
    step();
    chk_quiet("rst_acc");
    chk("rst_acc_maddr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    req0(1'b0, 32'h20, 32'h0);
    req1(1'b0, 32'h0, 32'h0);
    step();
    chk("post_rst_gnt", {bus.p0_gnt, bus.p1_gnt}, 2'b10);
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    step();
    chk("post_rst_rdata", bus.p0_rdata, 32'h0000_0055);
    step();
    step();
    chk_quiet("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and access sequencer for the shared byte-addressed, word-wide data memory. It sits between two requesters and the memory's write data, address, write strobe, read strobe and read data pins. Port 0 is the pipeline MEM stage; port 1 is the debug/loader port. It applies fixed priority to port 0 with an aging guard for port 1, checks alignment and range, drives the memory strobes for exactly one cycle per access, and returns a registered response.

## Interface
Parameters:
- MEM_BYTES, 1024: memory size in bytes. Legal word addresses are 0 .. MEM_BYTES-4.
- MAX_WAIT, 4: number of consecutive lost arbitrations after which port 1 wins.

Ports:
- clk  in  1  single clock. Memory samples strobes on negedge.
- rst_n  in  1  synchronous, active-low reset.
- p0_req, p1_req  in  1  request. Held with its fields until the grant is seen.
- p0_we, p1_we  in  1  1 = write, 0 = read.
- p0_addr, p1_addr  in  32  byte address.
- p0_wdata, p1_wdata  in  32  write data.
- p0_gnt, p1_gnt  out  1  one-cycle grant pulse.
- p0_rvalid, p1_rvalid  out  1  one-cycle response pulse.
- p0_rdata, p1_rdata  out  32  read data. Valid with rvalid; 0 for writes and errors.
- p0_err, p1_err  out  1  error flag, qualified by rvalid.
- mem_addr  out  32  to memory address.
- mem_wdata  out  32  to memory write data.
- mem_write  out  1  to memory write strobe.
- mem_read  out  1  to memory read strobe.
- mem_rdata  in  32  from memory read data.

## Operation
- States:
  - IDLE: arbitrate at each posedge.
  - ACCESS: one cycle; strobes driven from registered command.
  - RESP: one cycle; response driven; arbitrate again.
- IDLE/RESP → ACCESS when any req is sampled. Otherwise IDLE. ACCESS → RESP always.
- Arbitration when both ports request:
  - Port 0 wins, unless wait_cnt == MAX_WAIT, in which case port 1 wins.
  - If only one port requests, it wins.
- wait_cnt (width ≥ clog2(MAX_WAIT+1)):
  - Increments, saturating at MAX_WAIT, on each arbitration where p1_req=1 and port 0 wins.
  - Clears to 0 when port 1 is granted.
  - Unchanged otherwise.
- On a win, the winner's we/addr/wdata/port-id are registered. Requester inputs are not sampled again for this access.
- Error check, done at arbitration: addr[1:0] != 0 or addr > MEM_BYTES-4 → err.
  - On err, ACCESS keeps mem_write=0 and mem_read=0. Memory is untouched.
  - Response: rvalid=1, err=1, rdata=0.
- ACCESS with no err:
  - mem_addr and mem_wdata come from the registers.
  - mem_write = we; mem_read = ~we.
  - At the end-of-ACCESS posedge, mem_rdata is captured for reads.
- Responses go only to the granted port. All outputs of the other port stay 0.
- Outside ACCESS, mem_write and mem_read are 0. mem_addr and mem_wdata hold their last value.

## Timing
- Edge E0 samples req. Cycle C1 = ACCESS: gnt=1 and strobes asserted; memory acts on negedge of C1.
- Edge E1 captures mem_rdata. Cycle C2 = RESP: rvalid, rdata and err asserted.
- Latency is 2 cycles from the sampling edge to rvalid.
- Requesters drop or replace req at E1 (after seeing gnt). A req sampled at E2 is a new request.
- Throughput is back-to-back from RESP: one access per 2 cycles. Alternating winners are allowed.
- Reset: any posedge with rst_n=0 forces the following state:
  - State IDLE, wait_cnt=0.
  - All gnt, rvalid, err, rdata outputs = 0.
  - mem_write = mem_read = 0; mem_addr = mem_wdata = 0.
- Reset during ACCESS: the response is dropped.
  - The memory write at that cycle's negedge has already occurred if the reset edge is later.
  - Reset asserted at the ACCESS posedge (E0) prevents the strobes entirely.
- rst_n released: first arbitration happens at the first posedge with rst_n=1.

## Test plan
- Reset, then idle 5 cycles → all outputs 0 and state IDLE. Reassert rst_n low mid-run → outputs 0 the cycle after.
- Write, then read back:
  - p0 write addr 0x8, data 0xDEADBEEF → p0_gnt in C1, mem_write=1 for 1 cycle, p0_rvalid in C2 with err=0.
  - p0 read 0x8 → p0_rdata=0xDEADBEEF exactly 2 cycles after the sampling edge.
- p0 and p1 request the same edge (p0 read 0x0, p1 write 0x10=0x12345678):
  - p0 granted first and p1 granted at the following RESP edge, giving 2 accesses in 4 cycles.
  - Memory at 0x10 then reads back 0x12345678.
- Starvation, MAX_WAIT=4: p0_req and p1_req held high continuously.
  - p0 wins 4 arbitrations, p1 wins the 5th, then the pattern repeats.
- Bad addresses:
  - p1 read 0x6 → p1_err=1, rdata=0, mem_read never asserted.
  - p0 write 0x3FE and write 0x400 → err=1, and reads at 0x3FC are unchanged.
- Reset during ACCESS of a p1 write → no p1_rvalid. wait_cnt=0; a subsequent simultaneous request grants p0.
